z_accumulator: RTL
==================

Z_ACCUMULATOR -- requirements
Module: z_accumulator

Interface
- REQ-001: Parameter DEPTH, default 4: input FIFO entries; power of two, range 2..16.
- REQ-002: Parameter BLOCK, default 4: samples summed per output; power of two, range 2..16.
- REQ-003: Port clock, input, 1: sole clock; all state changes on its rising edge.
- REQ-004: Port reset, input, 1: synchronous, active-high reset.
- REQ-005: Port io_in_valid, input, 1: upstream io_z sample present.
- REQ-006: Port io_in_ready, output, 1: block can accept a sample this cycle.
- REQ-007: Port io_in_bits, input, 16: unsigned sample, i.e. upstream stage result io_z.
- REQ-008: Port io_out_valid, output, 1: block sum available.
- REQ-009: Port io_out_ready, input, 1: downstream accepts the sum.
- REQ-010: Port io_out_bits, output, 20: unsigned block sum.
- REQ-011: Port io_occupancy, output, 5: current FIFO entry count.

Function
- REQ-012: Input transfer occurs iff io_in_valid and io_in_ready in the same cycle; the sample is written to the FIFO tail at that edge.
- REQ-013: io_in_ready is high iff occupancy < DEPTH; it does not depend on a same-cycle pop.
- REQ-014: Simultaneous push and pop leave occupancy unchanged and preserve FIFO order.
- REQ-015: FIFO pointers wrap modulo DEPTH; occupancy ranges 0..DEPTH, with no overflow or underflow.
- REQ-016: FSM states are ACCUM and EMIT.
- REQ-017: In ACCUM, one entry is popped per cycle when occupancy > 0, and added to the accumulator; sample counter increments.
- REQ-018: The accumulator is cleared at the edge the FSM enters ACCUM, so the first pop of a block loads the sample directly.
- REQ-019: On the BLOCK-th pop, the final sum registers into io_out_bits and the FSM moves to EMIT; io_out_valid is high the following cycle.
- REQ-020: Minimum latency is BLOCK+1 cycles from the first input transfer of a block to io_out_valid, given back-to-back input.
- REQ-021: In EMIT, io_out_valid is high and io_out_bits is stable; no pops occur; pushes continue until the FIFO is full.
- REQ-022: Output transfer occurs on io_out_valid and io_out_ready; the FSM returns to ACCUM at that edge, and may pop in the next cycle.
- REQ-023: An empty FIFO in ACCUM stalls accumulation; partial sums are held indefinitely.
- REQ-024: Arithmetic is unsigned and zero-extended to 20 bits; the maximum sum, 16 x 0xFFFF = 0xFFFF0, never wraps.

Reset
- REQ-025: When reset is high at an edge, the FIFO is emptied, the accumulator and counter are zeroed, and the FSM enters ACCUM.
- REQ-026: Reset values: io_out_valid=0, io_out_bits=0, io_occupancy=0, io_in_ready=1 from the first post-reset cycle.
- REQ-027: Reset mid-block or in EMIT discards the partial or pending sum without producing an output; any input transfer in the reset cycle is dropped.

Configuration
- REQ-028: Macro Z_ACCUMULATOR_SATURATE_EN defined: io_out_bits clamps to 0x0FFFF when the true sum exceeds 0xFFFF.
- REQ-029: Macro Z_ACCUMULATOR_SATURATE_EN undefined: io_out_bits is the full 20-bit sum.

Structure
- REQ-030: Shared package z_accumulator_pkg holds SAMPLE_W=16, SUM_W=20, OCC_W=5, the state enum (ACCUM, EMIT), and SAT_MAX=20'h0FFFF.
- REQ-031: The FIFO is one sub-module, z_fifo, parameterised by DEPTH and width, exposing push, pop, full, empty and count.

Verification
- REQ-032: Reset, then inputs 1,2,3,4 back-to-back with io_out_ready=1 -> io_out_valid for one cycle at 5 cycles after the first transfer, io_out_bits=10.
- REQ-033: Eight samples of 0xFFFF with BLOCK=4 -> sums 0x3FFFC, 0x3FFFC without the macro; 0x0FFFF, 0x0FFFF with Z_ACCUMULATOR_SATURATE_EN.
- REQ-034: Hold io_out_ready=0 after the first sum while io_in_valid=1 -> io_occupancy reaches 4, io_in_ready=0, io_out_bits stable; on release, the next sum follows in order.
- REQ-035: Input gaps (valid on samples 5, idle 3 cycles, then 6,7,8) -> single sum 26; no output during the stall.
- REQ-036: Assert reset after 2 of 4 samples (values 9,9) -> no output; a following block 1,1,1,1 -> io_out_bits=4.
- REQ-037: Push and pop in the same cycle at occupancy 2 -> occupancy stays 2; output sums match a reference model over 100 random samples, including pointer wrap.

Source files
------------

// File: rtl/z_accumulator_pkg.sv
// Shared widths, saturation limit and FSM state type for the z_accumulator block.
package z_accumulator_pkg;

  localparam int SAMPLE_W = 16;
  localparam int SUM_W    = 20;
  localparam int OCC_W    = 5;

  localparam logic [SUM_W-1:0] SAT_MAX = 20'h0FFFF;

  typedef enum logic {
    ACCUM,
    EMIT
  } state_e;

  function automatic logic [SUM_W-1:0] clamp_sum(input logic [SUM_W-1:0] s);
    return (s > SAT_MAX) ? SAT_MAX : s;
  endfunction

endpackage

// File: rtl/z_fifo.sv
// Synchronous FIFO with power-of-two depth, wrapping pointers and an entry count.
module z_fifo
  import z_accumulator_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = SAMPLE_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [OCC_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == OCC_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/z_accumulator.sv
// Buffers io_z samples in a FIFO and emits the sum of every BLOCK samples.
// Define Z_ACCUMULATOR_SATURATE_EN to clamp emitted sums to SAT_MAX.
module z_accumulator
  import z_accumulator_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int BLOCK = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_in_valid,
  output logic                io_in_ready,
  input  logic [SAMPLE_W-1:0] io_in_bits,
  output logic                io_out_valid,
  input  logic                io_out_ready,
  output logic [SUM_W-1:0]    io_out_bits,
  output logic [OCC_W-1:0]    io_occupancy
);

  localparam int                CNT_W    = $clog2(BLOCK) + 1;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(BLOCK - 1);

  state_e              state_q, state_d;
  logic [SUM_W-1:0]    acc_q, acc_d;
  logic [SUM_W-1:0]    out_q, out_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SUM_W-1:0]    sum_next;
  logic [SUM_W-1:0]    sum_final;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [SAMPLE_W-1:0] fifo_data;
  logic [OCC_W-1:0]    fifo_count;

  z_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (io_in_bits),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign io_in_ready  = !fifo_full;
  assign fifo_push    = io_in_valid && io_in_ready;
  assign fifo_pop     = (state_q == ACCUM) && !fifo_empty;
  assign sum_next     = acc_q + SUM_W'(fifo_data);
  assign io_out_valid = (state_q == EMIT);
  assign io_out_bits  = out_q;
  assign io_occupancy = fifo_count;

`ifdef Z_ACCUMULATOR_SATURATE_EN
  assign sum_final = clamp_sum(sum_next);
`else
  assign sum_final = sum_next;
`endif

  // Accumulator is cleared on the way back into ACCUM, so a block's first pop loads directly.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    case (state_q)
      ACCUM: begin
        if (fifo_pop) begin
          acc_d = sum_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            out_d   = sum_final;
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (io_out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
